// File: rtl/aes_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_reg_sequencer
// Brief    : Bus-side master of the 16 x 32-bit AES register file. It polls
//            START, gathers key and message, runs the AES core, then writes
//            the result back, posts DONE and clears START.
// Options  : AES_SEQ_TIMEOUT_EN - adds a RUN watchdog that aborts a run after
//            TIMEOUT_CYCLES and posts an error code (2) in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module aes_reg_sequencer #(
    parameter int unsigned KEY_BASE       = 0,
    parameter int unsigned MSG_BASE       = 4,
    parameter int unsigned RES_BASE       = 8,
    parameter int unsigned START_IDX      = 14,
    parameter int unsigned DONE_IDX       = 15
`ifdef AES_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic         Clk,
    input  logic         Reset,
    output logic [4:0]   REG_SELECT,
    output logic         REG_LD,
    output logic [31:0]  REG_WDATA,
    input  logic [31:0]  REG_RDATA,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_RESULT,
    output logic         BUSY
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CLR_DONE  = 3'd1;
    localparam logic [2:0] c_READ      = 3'd2;
    localparam logic [2:0] c_RUN       = 3'd3;
    localparam logic [2:0] c_WRITE     = 3'd4;
    localparam logic [2:0] c_SET_DONE  = 3'd5;
    localparam logic [2:0] c_CLR_START = 3'd6;

    localparam logic [4:0] c_KEY_BASE  = 5'(KEY_BASE);
    localparam logic [4:0] c_MSG_BASE  = 5'(MSG_BASE);
    localparam logic [4:0] c_RES_BASE  = 5'(RES_BASE);
    localparam logic [4:0] c_START_IDX = 5'(START_IDX);
    localparam logic [4:0] c_DONE_IDX  = 5'(DONE_IDX);

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [2:0]   r_cnt;
    logic [127:0] r_key;
    logic [127:0] r_msg;
    logic [127:0] r_result;
    logic [1:0]   w_word;
    logic [6:0]   w_bit_base;
    logic [31:0]  w_done_code;
    logic         w_timeout;

    // Word 0 lives in the top 32 bits, so word n sits at bit 32*(3-n).
    assign w_word     = 2'd3 - r_cnt[1:0];
    assign w_bit_base = {w_word, 5'd0};

`ifdef AES_SEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_err;

    // Watchdog fires on the RUN cycle that completes TIMEOUT_CYCLES without
    // AES_DONE; a simultaneous AES_DONE wins and takes the normal path.
    assign w_timeout   = (r_state == c_RUN) && !AES_DONE &&
                         (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_done_code = r_err ? 32'h0000_0002 : 32'h0000_0001;

    // Watchdog counter: zero outside RUN, counts each RUN cycle; error flag
    // remembers an aborted run until the next run starts.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_to_cnt <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == c_RUN) ? r_to_cnt + 16'd1 : 16'd0;
            if (r_state == c_CLR_DONE)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_done_code = 32'h0000_0001;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic: one register access per cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:      if (REG_RDATA[0]) w_next_state = c_CLR_DONE;
            c_CLR_DONE:  w_next_state = c_READ;
            c_READ:      if (r_cnt == 3'd7) w_next_state = c_RUN;
            c_RUN: begin
                if (AES_DONE)
                    w_next_state = c_WRITE;
                else if (w_timeout)
                    w_next_state = c_SET_DONE;
            end
            c_WRITE:     if (r_cnt == 3'd3) w_next_state = c_SET_DONE;
            c_SET_DONE:  w_next_state = c_CLR_START;
            c_CLR_START: w_next_state = c_IDLE;
            default:     w_next_state = c_IDLE;
        endcase
    end

    // Step counter for READ/WRITE and capture of key, message and result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt    <= 3'd0;
            r_key    <= 128'd0;
            r_msg    <= 128'd0;
            r_result <= 128'd0;
        end else begin
            if (w_next_state != r_state)
                r_cnt <= 3'd0;
            else if (r_state == c_READ || r_state == c_WRITE)
                r_cnt <= r_cnt + 3'd1;

            if (r_state == c_READ) begin
                if (r_cnt[2])
                    r_msg[w_bit_base +: 32] <= REG_RDATA;
                else
                    r_key[w_bit_base +: 32] <= REG_RDATA;
            end

            if (r_state == c_RUN && AES_DONE)
                r_result <= AES_RESULT;
        end
    end

    // Output decode: register-port controls, core start level and BUSY.
    always_comb begin
        REG_SELECT = c_START_IDX;
        REG_LD     = 1'b0;
        REG_WDATA  = 32'd0;
        AES_START  = 1'b0;
        BUSY       = 1'b1;
        case (r_state)
            c_IDLE: begin
                BUSY = 1'b0;
            end
            c_CLR_DONE: begin
                REG_SELECT = c_DONE_IDX;
                REG_LD     = 1'b1;
            end
            c_READ: begin
                REG_SELECT = (r_cnt[2] ? c_MSG_BASE : c_KEY_BASE) +
                             {3'b000, r_cnt[1:0]};
            end
            c_RUN: begin
                AES_START = 1'b1;
            end
            c_WRITE: begin
                REG_SELECT = c_RES_BASE + {3'b000, r_cnt[1:0]};
                REG_LD     = 1'b1;
                REG_WDATA  = r_result[w_bit_base +: 32];
            end
            c_SET_DONE: begin
                REG_SELECT = c_DONE_IDX;
                REG_LD     = 1'b1;
                REG_WDATA  = w_done_code;
            end
            c_CLR_START: begin
                REG_SELECT = c_START_IDX;
                REG_LD     = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    assign AES_KEY = r_key;
    assign AES_MSG = r_msg;

endmodule
`default_nettype wire

// File: tb/tb_aes_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_reg_sequencer
// Brief    : Directed self-checking bench for aes_reg_sequencer with a
//            behavioural register file and AES core model.
// Options  : AES_SEQ_TIMEOUT_EN - also exercises the watchdog (limit 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_reg_sequencer;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [4:0]   REG_SELECT;
    logic         REG_LD;
    logic [31:0]  REG_WDATA;
    logic [31:0]  REG_RDATA;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_RESULT;
    logic         BUSY;

    localparam logic [127:0] c_KEY = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    localparam logic [127:0] c_MSG = 128'h3243F6A8_885A308D_313198A2_E0370734;
    localparam logic [127:0] c_R1  = 128'h3925841D_02DC09FB_DC118597_196A0B32;
    localparam logic [127:0] c_R2  = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    int n_pass  = 0;
    int n_total = 0;

    // Register file model with a bench-side preload port.
    logic [31:0] mem [0:15];
    logic        tb_we;
    logic [3:0]  tb_widx;
    logic [31:0] tb_wdata;

    // Core model: DONE rises on RUN cycle number done_delay (0 = never).
    int   run_cnt = 0;
    int   done_delay;
    logic force_done;

    aes_reg_sequencer #(
        .KEY_BASE  (0),
        .MSG_BASE  (4),
        .RES_BASE  (8),
        .START_IDX (14),
        .DONE_IDX  (15)
`ifdef AES_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .REG_SELECT (REG_SELECT),
        .REG_LD     (REG_LD),
        .REG_WDATA  (REG_WDATA),
        .REG_RDATA  (REG_RDATA),
        .AES_KEY    (AES_KEY),
        .AES_MSG    (AES_MSG),
        .AES_START  (AES_START),
        .AES_DONE   (AES_DONE),
        .AES_RESULT (AES_RESULT),
        .BUSY       (BUSY)
    );

    always #5 Clk = ~Clk;

    // Register file write port.
    always @(posedge Clk) begin
        if (tb_we)
            mem[tb_widx] <= tb_wdata;
        else if (REG_LD && REG_SELECT < 5'd16)
            mem[REG_SELECT[3:0]] <= REG_WDATA;
    end

    // Register file combinational read port.
    always_comb begin
        REG_RDATA = 32'd0;
        if (REG_SELECT < 5'd16)
            REG_RDATA = mem[REG_SELECT[3:0]];
    end

    // Core model RUN cycle counter.
    always @(posedge Clk) begin
        if (!AES_START)
            run_cnt <= 0;
        else
            run_cnt <= run_cnt + 1;
    end

    // Core model done level.
    always_comb begin
        AES_DONE = force_done |
                   (AES_START && done_delay > 0 && run_cnt == done_delay - 1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tb_write(input int idx, input logic [31:0] data);
        tb_we    = 1'b1;
        tb_widx  = 4'(idx);
        tb_wdata = data;
        tick();
        tb_we    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Ticks while AES_START is high; bounded so a stuck core cannot hang.
    task automatic count_run(output int n);
        n = 0;
        while (AES_START && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (BUSY && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int bad;
        int n_run;
        int n_tail;

        Reset      = 1'b1;
        tb_we      = 1'b0;
        tb_widx    = 4'd0;
        tb_wdata   = 32'd0;
        force_done = 1'b0;
        done_delay = 11;
        AES_RESULT = c_R1;
        tick();
        tick();

        // Preload under reset.
        for (int i = 0; i < 4; i++) tb_write(i, c_KEY[(3 - i) * 32 +: 32]);
        for (int i = 0; i < 4; i++) tb_write(4 + i, c_MSG[(3 - i) * 32 +: 32]);
        for (int i = 0; i < 4; i++) tb_write(8 + i, 32'hAAAA_0000 + 32'(i));
        tb_write(12, 32'd0);
        tb_write(13, 32'd0);
        tb_write(14, 32'd0);
        tb_write(15, 32'hDEAD_BEEF);

        check("rst_busy",   128'(BUSY),       128'd0);
        check("rst_sel",    128'(REG_SELECT), 128'd14);
        check("rst_ld",     128'(REG_LD),     128'd0);
        check("rst_wdata",  128'(REG_WDATA),  128'd0);
        check("rst_start",  128'(AES_START),  128'd0);
        check("rst_key",    AES_KEY,          128'd0);
        check("rst_msg",    AES_MSG,          128'd0);

        // START stays 0 for 100 cycles.
        Reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (REG_LD !== 1'b0 || BUSY !== 1'b0 || REG_SELECT !== 5'd14) bad++;
        end
        check("idle_quiet", 128'(bad), 128'd0);

        // Main run: core answers on the 11th RUN cycle.
        tb_write(14, 32'd1);
        tick();
        check("clrd_sel",   128'(REG_SELECT), 128'd15);
        check("clrd_ld",    128'(REG_LD),     128'd1);
        check("clrd_wdata", 128'(REG_WDATA),  128'd0);
        check("clrd_busy",  128'(BUSY),       128'd1);
        tick();
        check("done_clr",   128'(mem[15]),    128'd0);
        check("rd0_sel",    128'(REG_SELECT), 128'd0);
        check("rd0_ld",     128'(REG_LD),     128'd0);
        check("rd0_wdata",  128'(REG_WDATA),  128'd0);
        for (int i = 0; i < 7; i++) tick();
        check("rd7_sel",    128'(REG_SELECT), 128'd7);
        tick();
        check("key",        AES_KEY,          c_KEY);
        check("msg",        AES_MSG,          c_MSG);
        check("start_rise", 128'(AES_START),  128'd1);
        count_run(n_run);
        check("run_len",    128'(n_run),      128'd11);
        check("wr0_sel",    128'(REG_SELECT), 128'd8);
        check("wr0_ld",     128'(REG_LD),     128'd1);
        check("wr0_wdata",  128'(REG_WDATA),  128'h3925841D);
        count_busy(n_tail);
        check("busy_len",   128'(9 + n_run + n_tail), 128'd26);
        check("res0", 128'(mem[8]),  128'h3925841D);
        check("res1", 128'(mem[9]),  128'h02DC09FB);
        check("res2", 128'(mem[10]), 128'hDC118597);
        check("res3", 128'(mem[11]), 128'h196A0B32);
        check("done_set",  128'(mem[15]), 128'd1);
        check("start_clr", 128'(mem[14]), 128'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BUSY !== 1'b0) bad++;
        end
        check("no_rerun", 128'(bad), 128'd0);

        // AES_DONE held high before START: must not trigger anything in IDLE.
        force_done = 1'b1;
        AES_RESULT = c_R2;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (BUSY !== 1'b0 || REG_LD !== 1'b0) bad++;
        end
        check("done_idle", 128'(bad), 128'd0);
        tb_write(0, 32'h0BAD_F00D);
        tb_write(14, 32'd1);
        tick();
        for (int i = 0; i < 9; i++) tick();
        check("fd_start", 128'(AES_START), 128'd1);
        count_run(n_run);
        check("fd_run_len", 128'(n_run), 128'd1);
        count_busy(n_tail);
        check("fd_busy_len", 128'(9 + n_run + n_tail), 128'd16);
        check("fd_key_w0", AES_KEY,
              {32'h0BAD_F00D, c_KEY[95:0]});
        check("fd_res0", 128'(mem[8]),  128'h00112233);
        check("fd_res1", 128'(mem[9]),  128'h44556677);
        check("fd_res2", 128'(mem[10]), 128'h8899AABB);
        check("fd_res3", 128'(mem[11]), 128'hCCDDEEFF);
        check("fd_done", 128'(mem[15]), 128'd1);
        check("fd_startclr", 128'(mem[14]), 128'd0);
        force_done = 1'b0;

        // Reset in the middle of READ (counter 3).
        tb_write(14, 32'd1);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("mid_sel3", 128'(REG_SELECT), 128'd3);
        Reset = 1'b1;
        tick();
        check("mrst_busy",  128'(BUSY),       128'd0);
        check("mrst_sel",   128'(REG_SELECT), 128'd14);
        check("mrst_ld",    128'(REG_LD),     128'd0);
        check("mrst_start", 128'(AES_START),  128'd0);
        check("mrst_key",   AES_KEY,          128'd0);
        check("mrst_done_kept", 128'(mem[15]), 128'd0);
        tb_write(14, 32'd0);
        Reset = 1'b0;
        tick();
        tick();
        check("mrst_idle", 128'(BUSY), 128'd0);

`ifdef AES_SEQ_TIMEOUT_EN
        // Watchdog: core never answers.
        for (int i = 0; i < 4; i++) tb_write(8 + i, 32'h5555_0000 + 32'(i));
        tb_write(0, c_KEY[127:96]);
        done_delay = 0;
        tb_write(14, 32'd1);
        tick();
        for (int i = 0; i < 9; i++) tick();
        count_run(n_run);
        check("to_run_len", 128'(n_run), 128'd16);
        count_busy(n_tail);
        check("to_done",  128'(mem[15]), 128'd2);
        check("to_start", 128'(mem[14]), 128'd0);
        for (int i = 0; i < 4; i++)
            check("to_res_kept", 128'(mem[8 + i]), 128'(32'h5555_0000 + 32'(i)));
        check("to_idle", 128'(BUSY), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
